// File: rtl/conv2_pe_row_ctrl_if.sv
// Handshake/data bundle around the conv2 PE row sequencer: weight port, ifmap port, PE row drive and psum output.
// master = sequencer side, slave = weight SRAM / line buffer / PE row / psum sink side.
interface conv2_pe_row_ctrl_if #(
    parameter int NUM_PE = 3
);
    logic              w_valid;
    logic              w_ready;
    logic [23:0]       w_data;
    logic [NUM_PE-1:0] pe_w_we;
    logic [23:0]       pe_w_data;
    logic              if_valid;
    logic              if_ready;
    logic [7:0]        if_data;
    logic              pe_en;
    logic [7:0]        pe_ifmap;
    logic [19:0]       pe_psum;
    logic              out_valid;
    logic              out_ready;
    logic [19:0]       out_data;
    logic              out_last;

    modport master (
        input  w_valid, w_data, if_valid, if_data, pe_psum, out_ready,
        output w_ready, pe_w_we, pe_w_data, if_ready, pe_en, pe_ifmap, out_valid, out_data, out_last
    );

    modport slave (
        output w_valid, w_data, if_valid, if_data, pe_psum, out_ready,
        input  w_ready, pe_w_we, pe_w_data, if_ready, pe_en, pe_ifmap, out_valid, out_data, out_last
    );
endinterface

// File: rtl/conv2_pe_row_ctrl.sv
// Sequencer for one conv2 PE row: loads kernel words, streams ifmap pixels, tags valid windows to the psum port.
// Latency: psum leaves PIPE_LAT enabled cycles after the pixel that completes its window; done one cycle after last psum.
// Backpressure: out_valid & ~out_ready freezes the whole PE pipe (pe_en=0, if_ready=0). Optional CONV2_CTRL_PERF_EN adds perf counters.
module conv2_pe_row_ctrl #(
    parameter int K        = 3,
    parameter int NUM_PE   = 3,
    parameter int PIPE_LAT = 2,
    parameter int DIM_W    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [DIM_W-1:0]   cfg_img_w,
    input  logic [DIM_W-1:0]   cfg_img_h,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
`ifdef CONV2_CTRL_PERF_EN
    output logic [31:0]        perf_cycles,
    output logic [31:0]        perf_stalls,
`endif
    conv2_pe_row_ctrl_if.master io
);
    localparam int WCNT_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int DCNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DIM_W-1:0]  K_M1       = DIM_W'(K - 1);
    localparam logic [WCNT_W-1:0] WCNT_LAST  = WCNT_W'(NUM_PE - 1);
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(PIPE_LAT - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD_W, S_RUN, S_DRAIN, S_WAIT_OUT} state_t;

    state_t              state_q, state_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                cfg_err_q, cfg_err_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [DCNT_W-1:0]   drain_q, drain_d;
    logic [DIM_W-1:0]    col_q, col_d, row_q, row_d;
    logic [DIM_W-1:0]    img_w_q, img_w_d, img_h_q, img_h_d;
    logic [PIPE_LAT-1:0] tag_q, tag_d, last_q, last_d;

    logic out_vld, stall, run_acc, advance, out_hs, w_hs, cfg_ok, col_end, row_end, tag_in, last_in, start_ok;

    assign out_vld  = tag_q[PIPE_LAT-1];
    assign cfg_ok   = (cfg_img_w > K_M1) && (cfg_img_h > K_M1);
    assign start_ok = (state_q == S_IDLE) && start && cfg_ok;

    always_comb begin
        stall   = out_vld & ~io.out_ready;
        run_acc = (state_q == S_RUN) & io.if_valid & ~stall;
        advance = run_acc | ((state_q == S_DRAIN) & ~stall);
        out_hs  = out_vld & io.out_ready;
        w_hs    = io.w_valid & (state_q == S_LOAD_W);
        col_end = (col_q == img_w_q - 1'b1);
        row_end = (row_q == img_h_q - 1'b1);
        // Windows straddling a row boundary (col < K-1) never get a tag.
        tag_in  = run_acc & (col_q >= K_M1) & (row_q >= K_M1);
        last_in = run_acc & col_end & row_end;

        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        wcnt_d    = wcnt_q;
        drain_d   = drain_q;
        col_d     = col_q;
        row_d     = row_q;
        img_w_d   = img_w_q;
        img_h_d   = img_h_q;

        case (state_q)
            S_IDLE: begin
                if (start && cfg_ok) begin
                    state_d = S_LOAD_W;
                    busy_d  = 1'b1;
                    img_w_d = cfg_img_w;
                    img_h_d = cfg_img_h;
                    wcnt_d  = '0;
                    drain_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                end else if (start) begin
                    cfg_err_d = 1'b1;
                end
            end
            S_LOAD_W: begin
                if (w_hs) begin
                    if (wcnt_q == WCNT_LAST) state_d = S_RUN;
                    else                     wcnt_d  = wcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (run_acc) begin
                    if (col_end) begin
                        col_d = '0;
                        row_d = row_end ? '0 : row_q + 1'b1;
                        if (row_end) state_d = S_DRAIN;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (advance) begin
                    drain_d = drain_q + 1'b1;
                    if (drain_q == DRAIN_LAST) state_d = S_WAIT_OUT;
                end
            end
            default: ;
        endcase

        // The last psum can already handshake on the final drain beat.
        if ((state_q == S_DRAIN || state_q == S_WAIT_OUT) && out_hs && last_q[PIPE_LAT-1]) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end

        tag_d  = tag_q;
        last_d = last_q;
        if (advance) begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                tag_d[i]  = tag_q[i-1];
                last_d[i] = last_q[i-1];
            end
            tag_d[0]  = tag_in;
            last_d[0] = last_in;
        end else if (out_hs) begin
            // Consumed without the pipe moving: retire the tail so the psum is not re-sent.
            tag_d[PIPE_LAT-1]  = 1'b0;
            last_d[PIPE_LAT-1] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            wcnt_q    <= '0;
            drain_q   <= '0;
            col_q     <= '0;
            row_q     <= '0;
            img_w_q   <= '0;
            img_h_q   <= '0;
            tag_q     <= '0;
            last_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            wcnt_q    <= wcnt_d;
            drain_q   <= drain_d;
            col_q     <= col_d;
            row_q     <= row_d;
            img_w_q   <= img_w_d;
            img_h_q   <= img_h_d;
            tag_q     <= tag_d;
            last_q    <= last_d;
        end
    end

    always_comb begin
        io.pe_w_we = '0;
        for (int i = 0; i < NUM_PE; i++) io.pe_w_we[i] = w_hs && (wcnt_q == WCNT_W'(i));
    end

    assign io.pe_w_data = w_hs ? io.w_data : '0;
    assign io.w_ready   = (state_q == S_LOAD_W);
    assign io.if_ready  = (state_q == S_RUN) & ~stall;
    assign io.pe_en     = advance;
    assign io.pe_ifmap  = run_acc ? io.if_data : '0;
    assign io.out_valid = out_vld;
    assign io.out_data  = io.pe_psum;
    assign io.out_last  = out_vld & last_q[PIPE_LAT-1];
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;

`ifdef CONV2_CTRL_PERF_EN
    logic [31:0] perf_cycles_q, perf_cycles_d, perf_stalls_q, perf_stalls_d;

    always_comb begin
        perf_cycles_d = perf_cycles_q;
        perf_stalls_d = perf_stalls_q;
        if (start_ok) begin
            perf_cycles_d = '0;
            perf_stalls_d = '0;
        end else begin
            if (busy_q && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
            if ((stall || (state_q == S_RUN && !io.if_valid)) && perf_stalls_q != '1)
                perf_stalls_d = perf_stalls_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_cycles_q <= '0;
            perf_stalls_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_d;
            perf_stalls_q <= perf_stalls_d;
        end
    end

    assign perf_cycles = perf_cycles_q;
    assign perf_stalls = perf_stalls_q;
`endif
endmodule

// File: tb/tb_conv2_pe_row_ctrl.sv
// Directed bench for conv2_pe_row_ctrl; a toy PE row (psum = sum of last 3 pixels, 2 enabled stages) drives pe_psum.
module tb_conv2_pe_row_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] cfg_w = '0;
    logic [5:0] cfg_h = '0;
    logic       busy, done, cfg_err;
`ifdef CONV2_CTRL_PERF_EN
    logic [31:0] perf_cycles, perf_stalls;
`endif

    conv2_pe_row_ctrl_if #(.NUM_PE(3)) bus ();

    conv2_pe_row_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_img_w  (cfg_w),
        .cfg_img_h  (cfg_h),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err),
`ifdef CONV2_CTRL_PERF_EN
        .perf_cycles(perf_cycles),
        .perf_stalls(perf_stalls),
`endif
        .io         (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  tap_a = '0, tap_b = '0;
    logic [19:0] m_q = '0, psum_q = '0;
    always @(posedge clk) begin
        if (bus.pe_en) begin
            tap_a  <= bus.pe_ifmap;
            tap_b  <= tap_a;
            m_q    <= 20'(bus.pe_ifmap) + 20'(tap_a) + 20'(tap_b);
            psum_q <= m_q;
        end
    end
    assign bus.pe_psum = psum_q;

    int tests_run = 0;
    int tests_failed = 0;

    logic [23:0] wts [3];
    int          n_out, n_acc, n_pe_en, last_hs_cyc, done_cyc, stall_bad, stall_seen, timeout;
    logic        busy_at_done;
    logic [19:0] out_vals [8];
    logic        out_lasts [8];
    logic [2:0]  we_log [3];
    logic [23:0] wd_log [3];

    task automatic run_frame(input int w, input int h, input int stall_idx, input int stall_len,
                             input bit toggle, input bit poke_start);
        int p, cyc, nw, stall_left;
        logic [19:0] held;
        n_out = 0; n_acc = 0; n_pe_en = 0; last_hs_cyc = -1; done_cyc = -1;
        stall_bad = 0; stall_seen = 0; timeout = 0; busy_at_done = 1'b1; held = '0;
        for (int i = 0; i < 8; i++) begin out_vals[i] = '0; out_lasts[i] = 1'b0; end
        cfg_w = 6'(w); cfg_h = 6'(h); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nw = 0; cyc = 0;
        while (nw < 3 && cyc < 50) begin
            bus.w_valid = 1'b1; bus.w_data = wts[nw];
            #1;
            if (bus.w_ready) begin we_log[nw] = bus.pe_w_we; wd_log[nw] = bus.pe_w_data; nw++; end
            @(posedge clk); #1; cyc++;
        end
        bus.w_valid = 1'b0; bus.w_data = '0;
        if (nw < 3) timeout = 1;
        p = 1; cyc = 0; stall_left = stall_len;
        while (timeout == 0 && done_cyc < 0 && cyc < 600) begin
            bus.if_valid  = (p <= w * h) && (!toggle || (cyc % 2) == 0);
            bus.if_data   = 8'(p);
            bus.out_ready = 1'b1;
            start = poke_start && (cyc == 3);
            if (poke_start && cyc == 3) begin cfg_w = 6'd3; cfg_h = 6'd3; end
            #1;
            if (bus.out_valid && n_out == stall_idx && stall_left > 0) begin
                bus.out_ready = 1'b0;
                #1;
                if (stall_left == stall_len) held = bus.out_data;
                else if (bus.out_data !== held) stall_bad++;
                if (bus.pe_en || bus.if_ready) stall_bad++;
                stall_seen++; stall_left--;
            end
            if (done) begin done_cyc = cyc; busy_at_done = busy; end
            if (bus.pe_en) n_pe_en++;
            if (bus.if_valid && bus.if_ready) begin n_acc++; p++; end
            if (bus.out_valid && bus.out_ready) begin
                if (n_out < 8) begin out_vals[n_out] = bus.out_data; out_lasts[n_out] = bus.out_last; end
                if (bus.out_last) last_hs_cyc = cyc;
                n_out++;
            end
            @(posedge clk); #1; cyc++;
        end
        start = 1'b0; bus.if_valid = 1'b0; bus.if_data = '0; bus.out_ready = 1'b1;
        if (done_cyc < 0) timeout = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.if_valid = 1'b1; bus.w_valid = 1'b1; bus.if_data = 8'hAA; bus.w_data = 24'h123456;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({busy, done, cfg_err, bus.w_ready, bus.if_ready, bus.pe_en, bus.out_valid, bus.out_last} !== 8'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl got %b want 00000000",
                     {busy, done, cfg_err, bus.w_ready, bus.if_ready, bus.pe_en, bus.out_valid, bus.out_last});
        end
        tests_run++;
        if (bus.pe_w_we !== 3'b000) begin tests_failed++; $display("FAIL reset_we got %b want 000", bus.pe_w_we); end
        tests_run++;
        if (bus.pe_ifmap !== 8'h00 || bus.pe_w_data !== 24'h0) begin
            tests_failed++; $display("FAIL reset_data got %h/%h want 00/000000", bus.pe_ifmap, bus.pe_w_data);
        end
`ifdef CONV2_CTRL_PERF_EN
        tests_run++;
        if (perf_cycles !== 32'd0 || perf_stalls !== 32'd0) begin
            tests_failed++; $display("FAIL reset_perf got %0d/%0d want 0/0", perf_cycles, perf_stalls);
        end
`endif
        bus.if_valid = 1'b0; bus.w_valid = 1'b0; bus.if_data = '0; bus.w_data = '0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_frame(5, 3, -1, 0, 1'b0, 1'b0);
        tests_run++;
        if (timeout !== 0) begin tests_failed++; $display("FAIL basic_timeout got %0d want 0", timeout); end
        tests_run++;
        if ({we_log[0], we_log[1], we_log[2]} !== 9'b001_010_100) begin
            tests_failed++; $display("FAIL basic_we got %b %b %b want 001 010 100", we_log[0], we_log[1], we_log[2]);
        end
        tests_run++;
        if (wd_log[0] !== wts[0] || wd_log[2] !== wts[2]) begin
            tests_failed++; $display("FAIL basic_wdata got %h %h want %h %h", wd_log[0], wd_log[2], wts[0], wts[2]);
        end
        tests_run++;
        if (n_out !== 3) begin tests_failed++; $display("FAIL basic_count got %0d want 3", n_out); end
        tests_run++;
        if (out_vals[0] !== 20'd36 || out_vals[1] !== 20'd39 || out_vals[2] !== 20'd42) begin
            tests_failed++;
            $display("FAIL basic_psum got %0d %0d %0d want 36 39 42", out_vals[0], out_vals[1], out_vals[2]);
        end
        tests_run++;
        if ({out_lasts[0], out_lasts[1], out_lasts[2]} !== 3'b001) begin
            tests_failed++; $display("FAIL basic_last got %b%b%b want 001", out_lasts[0], out_lasts[1], out_lasts[2]);
        end
        tests_run++;
        if (done_cyc !== last_hs_cyc + 1 || busy_at_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_done got cyc %0d busy %b want cyc %0d busy 0", done_cyc, busy_at_done, last_hs_cyc + 1);
        end
        tests_run++;
        if (n_pe_en !== 17 || n_acc !== 15) begin
            tests_failed++; $display("FAIL basic_pe_en got %0d/%0d want 17/15", n_pe_en, n_acc);
        end
    endtask

    task automatic test_stall();
        run_frame(5, 3, 1, 4, 1'b0, 1'b0);
        tests_run++;
        if (stall_seen !== 4 || stall_bad !== 0) begin
            tests_failed++; $display("FAIL stall_hold got seen %0d bad %0d want 4/0", stall_seen, stall_bad);
        end
        tests_run++;
        if (n_out !== 3 || out_vals[1] !== 20'd39 || out_lasts[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL stall_out got n %0d v1 %0d last %b want 3 39 1", n_out, out_vals[1], out_lasts[2]);
        end
        tests_run++;
        if (n_pe_en !== 17 || timeout !== 0) begin
            tests_failed++; $display("FAIL stall_pe_en got %0d to %0d want 17 to 0", n_pe_en, timeout);
        end
`ifdef CONV2_CTRL_PERF_EN
        tests_run++;
        if (perf_stalls !== 32'd4) begin tests_failed++; $display("FAIL perf_stalls got %0d want 4", perf_stalls); end
`endif
    endtask

    task automatic test_toggle();
        run_frame(4, 4, -1, 0, 1'b1, 1'b0);
        tests_run++;
        if (n_out !== 4 || timeout !== 0) begin
            tests_failed++; $display("FAIL toggle_count got %0d to %0d want 4 to 0", n_out, timeout);
        end
        tests_run++;
        if (out_vals[0] !== 20'd30 || out_vals[1] !== 20'd33 || out_vals[2] !== 20'd42 || out_vals[3] !== 20'd45) begin
            tests_failed++;
            $display("FAIL toggle_psum got %0d %0d %0d %0d want 30 33 42 45",
                     out_vals[0], out_vals[1], out_vals[2], out_vals[3]);
        end
        tests_run++;
        if ({out_lasts[0], out_lasts[1], out_lasts[2], out_lasts[3]} !== 4'b0001) begin
            tests_failed++;
            $display("FAIL toggle_last got %b%b%b%b want 0001", out_lasts[0], out_lasts[1], out_lasts[2], out_lasts[3]);
        end
        tests_run++;
        if (n_pe_en !== 18 || n_acc !== 16) begin
            tests_failed++; $display("FAIL toggle_pe_en got %0d/%0d want 18/16", n_pe_en, n_acc);
        end
    endtask

    task automatic test_cfg_err();
        cfg_w = 6'd2; cfg_h = 6'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        tests_run++;
        if ({cfg_err, busy, bus.w_ready} !== 3'b100) begin
            tests_failed++; $display("FAIL cfg_err_w got %b want 100", {cfg_err, busy, bus.w_ready});
        end
        @(posedge clk); #1;
        tests_run++;
        if ({cfg_err, busy, bus.w_ready} !== 3'b000) begin
            tests_failed++; $display("FAIL cfg_err_pulse got %b want 000", {cfg_err, busy, bus.w_ready});
        end
        cfg_w = 6'd5; cfg_h = 6'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        tests_run++;
        if ({cfg_err, busy} !== 2'b10) begin
            tests_failed++; $display("FAIL cfg_err_h got %b want 10", {cfg_err, busy});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_min_frame();
        run_frame(3, 3, -1, 0, 1'b0, 1'b0);
        tests_run++;
        if (n_out !== 1 || out_vals[0] !== 20'd24 || out_lasts[0] !== 1'b1 || timeout !== 0) begin
            tests_failed++;
            $display("FAIL min_frame got n %0d v %0d last %b to %0d want 1 24 1 0",
                     n_out, out_vals[0], out_lasts[0], timeout);
        end
    endtask

    task automatic test_reset_mid_run();
        int nw, acc, cyc, dones;
        cfg_w = 6'd5; cfg_h = 6'd3; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        nw = 0; cyc = 0;
        while (nw < 3 && cyc < 20) begin
            bus.w_valid = 1'b1; bus.w_data = wts[nw];
            #1;
            if (bus.w_ready) nw++;
            @(posedge clk); #1; cyc++;
        end
        bus.w_valid = 1'b0;
        acc = 0; cyc = 0;
        while (acc < 6 && cyc < 30) begin
            bus.if_valid = 1'b1; bus.if_data = 8'(acc + 1);
            #1;
            if (bus.if_ready) acc++;
            @(posedge clk); #1; cyc++;
        end
        tests_run++;
        if (acc !== 6 || busy !== 1'b1) begin
            tests_failed++; $display("FAIL midrst_setup got acc %0d busy %b want 6 1", acc, busy);
        end
        rst_n = 1'b0; bus.w_valid = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if ({busy, done, bus.w_ready, bus.if_ready, bus.pe_en, bus.out_valid} !== 6'b0 ||
            bus.pe_ifmap !== 8'h00 || bus.pe_w_we !== 3'b000) begin
            tests_failed++;
            $display("FAIL midrst_outputs got %b ifmap %h we %b want 000000 00 000",
                     {busy, done, bus.w_ready, bus.if_ready, bus.pe_en, bus.out_valid}, bus.pe_ifmap, bus.pe_w_we);
        end
        rst_n = 1'b1; bus.if_valid = 1'b0; bus.w_valid = 1'b0;
        dones = 0;
        repeat (5) begin @(posedge clk); #1; if (done || busy) dones++; end
        tests_run++;
        if (dones !== 0) begin tests_failed++; $display("FAIL midrst_no_done got %0d want 0", dones); end
        run_frame(5, 3, -1, 0, 1'b0, 1'b0);
        tests_run++;
        if (n_out !== 3 || out_vals[0] !== 20'd36 || out_vals[2] !== 20'd42 || out_lasts[2] !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrst_clean got n %0d v0 %0d v2 %0d last %b want 3 36 42 1",
                     n_out, out_vals[0], out_vals[2], out_lasts[2]);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(4, 3, -1, 0, 1'b0, 1'b1);
        tests_run++;
        if (n_out !== 2 || out_vals[0] !== 20'd30 || out_vals[1] !== 20'd33 ||
            {out_lasts[0], out_lasts[1]} !== 2'b01) begin
            tests_failed++;
            $display("FAIL b2b_first got n %0d v %0d %0d last %b%b want 2 30 33 01",
                     n_out, out_vals[0], out_vals[1], out_lasts[0], out_lasts[1]);
        end
        run_frame(5, 3, -1, 0, 1'b0, 1'b0);
        tests_run++;
        if (n_out !== 3 || out_vals[2] !== 20'd42 || timeout !== 0) begin
            tests_failed++;
            $display("FAIL b2b_second got n %0d v2 %0d to %0d want 3 42 0", n_out, out_vals[2], timeout);
        end
    endtask

    initial begin
        wts[0] = 24'h030201; wts[1] = 24'h060504; wts[2] = 24'h090807;
        bus.w_valid = 1'b0; bus.w_data = '0; bus.if_valid = 1'b0; bus.if_data = '0; bus.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_stall();
        test_toggle();
        test_cfg_err();
        test_min_frame();
        test_reset_mid_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
